// File: rtl/serial_pattern_generator.sv
// Serial bit-pattern transmitter: sends a latched PAT_W-bit pattern MSB-first,
// repeated repeat_cnt times with gap idle cycles between repetitions.
module serial_pattern_generator #(
  parameter int   PAT_W    = 4,
  parameter int   CNT_W    = 8,
  parameter int   GAP_W    = 4,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_end,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] reps_left_q, reps_left_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             frame_end_q, frame_end_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Outputs are derived from the next state so they register alongside it:
  // the cycle after a state is entered shows exactly that state's outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    reps_left_d = reps_left_q;
    gap_cnt_d   = gap_cnt_q;
    gap_len_d   = gap_len_q;
    pat_d       = pat_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && (repeat_cnt != '0)) begin
          state_d     = S_SEND;
          idx_d       = IDX_TOP;
          reps_left_d = repeat_cnt;
          pat_d       = pattern;
          gap_len_d   = gap;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (idx_q == '0) begin
          if (reps_left_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            reps_left_d = reps_left_q - CNT_W'(1);
            idx_d       = IDX_TOP;
            if (gap_len_q != '0) begin
              state_d   = S_GAP;
              gap_cnt_d = gap_len_q;
            end
          end
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q == GAP_W'(1)) begin
          state_d = S_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    valid_d     = (state_d == S_SEND);
    busy_d      = (state_d != S_IDLE);
    dout_d      = valid_d ? pat_d[idx_d] : IDLE_BIT;
    frame_end_d = valid_d && (idx_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      reps_left_q <= '0;
      gap_cnt_q   <= '0;
      gap_len_q   <= '0;
      pat_q       <= '0;
      dout_q      <= IDLE_BIT;
      valid_q     <= 1'b0;
      frame_end_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      reps_left_q <= reps_left_d;
      gap_cnt_q   <= gap_cnt_d;
      gap_len_q   <= gap_len_d;
      pat_q       <= pat_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      frame_end_q <= frame_end_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign frame_end  = frame_end_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/serial_pattern_generator.md
# serial_pattern_generator

Serial bit-pattern transmitter. It emits a programmable PAT_W-bit pattern MSB-first on a single-bit line, repeated a programmable number of times with optional idle gaps. It drives serial sequence detectors in the design: stimulus source, loopback self-test and link training. Default pattern 4'b0110 with idle level 1, so idle filler cannot form a false 0110 match.

## Interface
Parameters:
- PAT_W, 4, pattern length in bits (≥2)
- CNT_W, 8, width of repetition counter
- GAP_W, 4, width of inter-pattern gap counter
- IDLE_BIT, 1'b1, level driven on dout when not sending pattern bits

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only in IDLE
- abort  in  1  synchronous cancel of a running transfer
- pattern  in  PAT_W  pattern, transmitted MSB first; latched at accepted start
- repeat_cnt  in  CNT_W  number of pattern repetitions; latched at accepted start
- gap  in  GAP_W  idle cycles between repetitions; latched at accepted start
- dout  out  1  serial data
- dout_valid  out  1  high while dout carries a pattern bit
- frame_end  out  1  high with the last bit of each repetition
- busy  out  1  high from first bit through last bit/gap of the transfer
- done  out  1  one-cycle pulse after the final bit of a completed transfer

## Operation
- All outputs are registered. Reset values: dout=IDLE_BIT, dout_valid=0, frame_end=0, busy=0, done=0. The FSM resets to IDLE.
- FSM states: IDLE, SEND, GAP.
- **IDLE:**
  - dout=IDLE_BIT, valid=0, busy=0.
  - start=1 and repeat_cnt≠0: latch pattern, repeat_cnt and gap. Set bit index to PAT_W-1 and go to SEND.
  - start=1 and repeat_cnt=0: ignored. No busy, no done.
- **SEND:**
  - Each cycle: dout=pattern_q[idx], valid=1, busy=1. idx decrements.
  - frame_end=1 on idx=0.
  - After the idx=0 bit, with reps_left=1: go to IDLE and assert done for exactly one cycle (dout=IDLE_BIT, valid=0, busy=0).
  - After the idx=0 bit, with reps_left>1: decrement reps_left and reload idx=PAT_W-1. If gap_q=0, go to SEND with no bubble; otherwise go to GAP.
- **GAP:**
  - dout=IDLE_BIT, valid=0, busy=1 for exactly gap_q cycles, then SEND.
- **start while busy:** ignored. Input changes while busy have no effect, because latched copies are used.
- **abort=1 in SEND or GAP:** the next cycle is IDLE with reset-value outputs. done is not asserted. abort in IDLE has no effect. abort has priority over all SEND/GAP transitions.
- **rst:** has priority over everything. rst mid-transfer yields reset-value outputs at the next edge, with no done.
- **start and the done cycle coinciding:** the FSM is in IDLE during the done cycle, so a start there is accepted. The new first bit appears in the following cycle.
- **Counter widths:** reps_left is CNT_W wide and idx is clog2(PAT_W) wide. repeat_cnt=2^CNT_W-1 must complete without wrap.

## Timing
- Start accepted at edge E. The first bit is on dout after E, i.e. 1 cycle latency.
- One repetition occupies PAT_W cycles. Each gap adds gap_q cycles.
- Total busy cycles = R·PAT_W + (R-1)·G.
- done is high in the cycle immediately after the last frame_end cycle.
- Minimum start-to-start spacing: busy cycles + 1.
- frame_end aligns with the final pattern bit, the same cycle a Mealy detector on dout fires.

## Test plan
- **Single frame:** pattern=0110, repeat_cnt=1, gap=0.
  - dout=0,1,1,0 with valid=1 in cycles 1–4 after start.
  - frame_end in cycle 4, done in cycle 5, then dout=1, busy=0.
- **Repeats with gap:** pattern=0110, repeat_cnt=3, gap=2.
  - dout = 0110 11 0110 11 0110.
  - frame_end at cycles 4, 10, 16; done at 17; busy high for cycles 1–16.
- **Back-to-back repeats:** repeat_cnt=2, gap=0.
  - dout = 01100110 with valid continuously high for 8 cycles; done at cycle 9.
  - Loopback into a Mealy 0110 non-overlapping detector gives exactly 2 detect pulses, coincident with frame_end.
- **Ignored starts:**
  - start pulsed in cycle 2 of a transfer with a different pattern (1010): the output stream is unchanged.
  - start with repeat_cnt=0: busy, valid and done stay 0.
- **Abort:** abort in cycle 3 of repeat_cnt=2.
  - Cycle 4 onward: dout=1, valid=0, busy=0; done never asserts.
  - A new start after that sends a full frame.
- **Reset and start-in-done:**
  - rst asserted mid-GAP: all outputs at reset values after the next edge.
  - start during a done cycle: the next frame begins the following cycle.
